// File: rtl/ring_john_sched_pkg.sv
// Shared types and constants for the ring/Johnson enable scheduler.
package ring_john_sched_pkg;

    localparam int LEN_W_DEF = 4;

    // Requester ids, also used as bit positions in 2-bit request/grant vectors
    localparam int RING = 0;
    localparam int JOHN = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN_RING  = 3'd1,
        RUN_JOHN  = 3'd2,
        DONE_RING = 3'd3,
        DONE_JOHN = 3'd4,
        GAP       = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers who finished last and favours the other on a tie.
module rr_arb2
    import ring_john_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] done,
    output logic [1:0] win
);

    // last_john=1 means the Johnson requester was the most recently completed
    logic last_john;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_john <= 1'b1;
        end else if (done[RING]) begin
            last_john <= 1'b0;
        end else if (done[JOHN]) begin
            last_john <= 1'b1;
        end
    end

    always_comb begin
        win       = 2'b00;
        win[RING] = req[RING] & (~req[JOHN] | last_john);
        win[JOHN] = req[JOHN] & (~req[RING] | ~last_john);
    end

endmodule

// File: rtl/ring_john_scheduler.sv
// Grants fixed-length enable bursts on the shared ring/Johnson counter pair, one requester at a time.
module ring_john_scheduler
    import ring_john_sched_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_ring,
    input  logic             req_john,
    input  logic [LEN_W-1:0] len_ring,
    input  logic [LEN_W-1:0] len_john,
    output logic             en1,
    output logic             en2,
    output logic             gnt_ring,
    output logic             gnt_john,
    output logic             done_ring,
    output logic             done_john,
    output logic             busy,
    output logic [LEN_W-1:0] remaining
);

    localparam logic [1:0] GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

    state_t           state, nstate;
    logic [LEN_W-1:0] rem_d;
    logic [1:0]       gap_q, gap_d;
    logic [1:0]       win;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({req_john, req_ring}),
        .done ({done_john, done_ring}),
        .win  (win)
    );

    always_comb begin
        nstate = state;
        rem_d  = remaining;
        gap_d  = gap_q;
        case (state)
            IDLE: begin
                // The burst length is captured into the down-counter at grant time
                if (win[RING]) begin
                    if (len_ring != '0) begin
                        nstate = RUN_RING;
                        rem_d  = len_ring;
                    end else begin
                        nstate = DONE_RING;
                    end
                end else if (win[JOHN]) begin
                    if (len_john != '0) begin
                        nstate = RUN_JOHN;
                        rem_d  = len_john;
                    end else begin
                        nstate = DONE_JOHN;
                    end
                end
            end
            RUN_RING, RUN_JOHN: begin
                rem_d = remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) begin
                    nstate = (state == RUN_RING) ? DONE_RING : DONE_JOHN;
                end
            end
            DONE_RING, DONE_JOHN: begin
                if (GAP_CYCLES > 0) begin
                    nstate = GAP;
                    gap_d  = GAP_LOAD;
                end else begin
                    nstate = IDLE;
                end
            end
            GAP: begin
                if (gap_q == 2'd0) begin
                    nstate = IDLE;
                end else begin
                    gap_d = gap_q - 2'd1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            gap_q     <= 2'd0;
            en1       <= 1'b0;
            en2       <= 1'b0;
            gnt_ring  <= 1'b0;
            gnt_john  <= 1'b0;
            done_ring <= 1'b0;
            done_john <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nstate;
            remaining <= rem_d;
            gap_q     <= gap_d;
            en1       <= (nstate == RUN_RING);
            en2       <= (nstate == RUN_JOHN);
            gnt_ring  <= (nstate == RUN_RING) || (nstate == DONE_RING);
            gnt_john  <= (nstate == RUN_JOHN) || (nstate == DONE_JOHN);
            done_ring <= (nstate == DONE_RING);
            done_john <= (nstate == DONE_JOHN);
            busy      <= (nstate != IDLE);
        end
    end

endmodule

// File: tb/tb_ring_john_scheduler.sv
// Scoreboard bench: expected bursts are queued when requests are driven and checked as enables/done pulses appear.
module tb_ring_john_scheduler;
    import ring_john_sched_pkg::*;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_ring = 1'b0, req_john = 1'b0;
    logic [LW-1:0] len_ring = '0, len_john = '0;
    logic          en1, en2, gnt_ring, gnt_john, done_ring, done_john, busy;
    logic [LW-1:0] remaining;

    ring_john_scheduler #(.LEN_W(LW), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_ring(req_ring), .req_john(req_john),
        .len_ring(len_ring), .len_john(len_john),
        .en1(en1), .en2(en2),
        .gnt_ring(gnt_ring), .gnt_john(gnt_john),
        .done_ring(done_ring), .done_john(done_john),
        .busy(busy), .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int len; } exp_t;
    typedef struct {
        logic rr, rj;
        logic [LW-1:0] lr, lj;
        int n;
        int id0, len0, id1, len1;
    } vec_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   run_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle, burst shape against the queue head
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            run_cnt = 0;
        end else begin
            chk("excl_en", int'(en1 & en2), 0);
            chk("excl_gnt", int'(gnt_ring & gnt_john), 0);
            if (en1 | en2) begin
                if (sbq.size() == 0) chk("en_unexpected", 1, 0);
                else begin
                    chk("en_id", int'(en2), sbq[0].id);
                    chk("remaining", int'(remaining), sbq[0].len - run_cnt);
                    chk("gnt_during_en", int'(en1 ? gnt_ring : gnt_john), 1);
                    chk("busy_during_en", int'(busy), 1);
                end
                run_cnt++;
            end else begin
                chk("remaining_not_run", int'(remaining), 0);
            end
            if (done_ring | done_john) begin
                if (sbq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    chk("done_id", int'(done_john), sbq[0].id);
                    chk("burst_len", run_cnt, sbq[0].len);
                    chk("gnt_at_done", int'(done_ring ? gnt_ring : gnt_john), 1);
                    void'(sbq.pop_front());
                end
                run_cnt = 0;
            end
        end
    end

    task automatic push(input int id, input int len);
        exp_t e;
        e.id = id;
        e.len = len;
        sbq.push_back(e);
    endtask

    // Requester side: drop req on its done (or both after ndone dones when hold) and wait for idle
    task automatic run_until_idle(input bit hold, input int ndone);
        int dn = 0;
        int cyc = 0;
        bit fin = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (done_ring | done_john) begin
                dn++;
                if (!hold) begin
                    if (done_ring) req_ring = 1'b0;
                    if (done_john) req_john = 1'b0;
                end else if (dn == ndone) begin
                    req_ring = 1'b0;
                    req_john = 1'b0;
                end
            end
            if (!busy && !req_ring && !req_john) fin = 1;
            if (cyc > 300) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout: no return to idle after %0d cycles", cyc);
                req_ring = 1'b0;
                req_john = 1'b0;
                fin = 1;
            end
        end
        chk("queue_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    vec_t vt[6];

    initial begin
        // {rr, rj, lr, lj, n, id0, len0, id1, len1}; order assumes last served = JOHN on entry
        vt[0] = '{1'b1, 1'b1, 4'd1,  4'd2,  2, RING, 1,  JOHN, 2};
        vt[1] = '{1'b0, 1'b1, 4'd7,  4'd15, 1, JOHN, 15, 0,    0};
        vt[2] = '{1'b1, 1'b1, 4'd0,  4'd3,  2, RING, 0,  JOHN, 3};
        vt[3] = '{1'b1, 1'b0, 4'd15, 4'd9,  1, RING, 15, 0,    0};
        vt[4] = '{1'b1, 1'b1, 4'd4,  4'd1,  2, JOHN, 1,  RING, 4};
        vt[5] = '{1'b1, 1'b1, 4'd0,  4'd0,  2, JOHN, 0,  RING, 0};

        // Reset then idle
        repeat (2) @(negedge clk);
        chk("rst_en1", int'(en1), 0);
        chk("rst_en2", int'(en2), 0);
        chk("rst_gnt", int'(gnt_ring | gnt_john), 0);
        chk("rst_done", int'(done_ring | done_john), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_remaining", int'(remaining), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Single ring burst with one-cycle grant latency
        push(RING, 3);
        len_ring = 4'd3;
        req_ring = 1'b1;
        @(negedge clk);
        chk("ring_latency_en1", int'(en1), 1);
        chk("ring_first_rem", int'(remaining), 3);
        run_until_idle(0, 0);

        // Zero-length Johnson burst
        push(JOHN, 0);
        len_john = 4'd0;
        req_john = 1'b1;
        @(negedge clk);
        chk("zero_gnt_john", int'(gnt_john), 1);
        chk("zero_done_john", int'(done_john), 1);
        chk("zero_en2", int'(en2), 0);
        req_john = 1'b0;
        run_until_idle(0, 0);

        // Both held: strict alternation ring, john, ring, john
        push(RING, 2); push(JOHN, 4); push(RING, 2); push(JOHN, 4);
        len_ring = 4'd2;
        len_john = 4'd4;
        req_ring = 1'b1;
        req_john = 1'b1;
        run_until_idle(1, 4);

        for (int i = 0; i < 6; i++) begin
            if (vt[i].n > 0) push(vt[i].id0, vt[i].len0);
            if (vt[i].n > 1) push(vt[i].id1, vt[i].len1);
            len_ring = vt[i].lr;
            len_john = vt[i].lj;
            req_ring = vt[i].rr;
            req_john = vt[i].rj;
            run_until_idle(0, 0);
        end

        // Length change and req drop mid-burst must not disturb it
        push(RING, 5);
        len_ring = 4'd5;
        req_ring = 1'b1;
        @(negedge clk);
        len_ring = 4'd1;
        @(negedge clk);
        req_ring = 1'b0;
        run_until_idle(0, 0);

        // Async reset in the 3rd Johnson enable cycle
        push(JOHN, 6);
        len_john = 4'd6;
        req_john = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_abort_en2", int'(en2), 1);
        #1 rst = 1'b0;
        #1;
        chk("abort_en2", int'(en2), 0);
        chk("abort_gnt_john", int'(gnt_john), 0);
        chk("abort_busy", int'(busy), 0);
        sbq.delete();
        req_john = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", int'(done_john), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", int'(busy | done_john), 0);
        // Last served was ring before reset; reset must restore ring priority
        push(RING, 2); push(JOHN, 1);
        len_ring = 4'd2;
        len_john = 4'd1;
        req_ring = 1'b1;
        req_john = 1'b1;
        @(negedge clk);
        chk("post_rst_ring_first", int'(en1), 1);
        run_until_idle(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_john_scheduler.md
Name: ring_john_scheduler

Overview:
- Time-multiplexes the shared ring/Johnson counter pair between two requesters.
- Drives the counter's en1 (ring) and en2 (Johnson) enables.
- Each requester asks for a burst of N enabled clock cycles. The scheduler grants bursts round-robin, guarantees en1/en2 are never high together, and signals completion per requester.
- Sits directly upstream of the counter pair; the qout buses are not touched.

Parameters:
- LEN_W, 4, width of burst-length inputs and remaining-count output.
- GAP_CYCLES, 1, idle cycles forced between consecutive bursts (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_ring  in  1  level request for a ring-counter burst; sampled only in IDLE.
- req_john  in  1  level request for a Johnson-counter burst; sampled only in IDLE.
- len_ring  in  LEN_W  ring burst length; latched at grant.
- len_john  in  LEN_W  Johnson burst length; latched at grant.
- en1  out  1  ring counter enable.
- en2  out  1  Johnson counter enable.
- gnt_ring  out  1  high while the ring requester owns the counter (RUN_RING, DONE_RING).
- gnt_john  out  1  high while the Johnson requester owns the counter (RUN_JOHN, DONE_JOHN).
- done_ring  out  1  one-cycle pulse at end of a ring burst.
- done_john  out  1  one-cycle pulse at end of a Johnson burst.
- busy  out  1  high in any state other than IDLE.
- remaining  out  LEN_W  enable cycles still to issue in the current burst; 0 outside RUN.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (rst=0, asynchronous assert, synchronous release):
  - state=IDLE, all outputs 0, remaining=0, gap counter 0.
  - last_served=JOHN, so the ring requester wins the first tie.
- States: IDLE, RUN_RING, RUN_JOHN, DONE_RING, DONE_JOHN, GAP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not equal to last_served.
  - On grant, latch the winner's len. If len!=0, next state is RUN_x with remaining=len. If len==0, next state is DONE_x directly; en never asserts.
- RUN_x:
  - en_x=1, gnt_x=1, remaining decrements each cycle.
  - When remaining==1, next state is DONE_x.
  - en_x is therefore high for exactly len consecutive cycles.
  - The first en_x cycle is the cycle after the IDLE cycle that saw the request (1-cycle grant latency).
- DONE_x:
  - en_x=0, done_x=1, gnt_x=1 for exactly one cycle; last_served<=x.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: hold for GAP_CYCLES cycles with all enables low, then go to IDLE.
- Requests are ignored outside IDLE. Deasserting req mid-burst does not abort the burst.
- Requester handshake: hold req until done_x, then drop it. If req is still high when the scheduler returns to IDLE, it is treated as a new request.
- Changes to len_x after grant have no effect on the current burst.
- Invariant: en1 & en2 == 0 in every cycle.
- Invariant: gnt_ring & gnt_john == 0 in every cycle.
- Max length 2^LEN_W-1; no wrap. len is an unsigned count.
- Reset mid-burst: en drops immediately (asynchronously) and no done pulse is issued for the aborted burst.

Decomposition:
- Package ring_john_sched_pkg holds:
  - state enum (6 states);
  - requester id localparams RING=0, JOHN=1;
  - default LEN_W.
- One natural sub-module, rr_arb2: a 2-way round-robin arbiter holding last_served, outputting a one-hot winner. It updates only on a done pulse.

Test Plan:
- Reset then idle: rst low for 2 cycles, no requests -> all outputs 0, busy=0, remaining=0.
- Single ring burst: req_ring=1, len_ring=3 -> en1 high exactly 3 cycles starting the cycle after the request is seen; remaining reads 3,2,1; done_ring pulses once; en2 stays 0.
- Simultaneous requests, both held (len_ring=2, len_john=4) -> ring served first (en1 ×2, done_ring), then GAP for 1 cycle, then Johnson (en2 ×4, done_john). Repeat the same stimulus -> order continues alternating ring, john, ring, john.
- Zero length: req_john=1, len_john=0 -> en2 never high; gnt_john high for 1 cycle with done_john pulse 1 cycle after the request is seen.
- Mid-burst disturbances: len_ring changed 5->1 during a 5-cycle burst, and req_ring dropped after 2 cycles -> en1 still high exactly 5 cycles, then done_ring.
- Async reset mid-burst: rst asserted in the 3rd en2 cycle between clock edges -> en2, gnt_john, busy go 0 immediately; no done_john; after release, a fresh req_ring is granted first.
